// File: rtl/button_event_arbiter.sv
// button_event_arbiter
// Serializes one-cycle press pulses from a debouncer bank into a single
// valid/ready event stream. Each press is latched in a pending bit, picked
// round-robin and offered once. A single shared repeat engine can re-offer
// the most recently accepted button while it stays held. A sticky overflow
// flag records presses that were lost because their pending bit was still set.
module button_event_arbiter #(
    parameter int N_BTN         = 4,
    parameter int IDX_W         = 2,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_pressed,
    input  logic [N_BTN-1:0] btn_state,
    input  logic             evt_ready,
    input  logic             clear_overflow,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_id,
    output logic             evt_repeat,
    output logic             overflow
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // Width of the wrap-around sum used by the round-robin search.
    localparam int          SUM_W    = IDX_W + 1;
    localparam logic [31:0] DELAY_C  = 32'(REPEAT_DELAY);
    localparam logic [31:0] PERIOD_C = 32'(REPEAT_PERIOD);
    // A zero delay means the repeat engine is never armed.
    localparam logic        REP_EN_C = (REPEAT_DELAY != 0);

    // Output FSM and registered outputs
    state_t             state_q;
    logic               evt_valid_q;
    logic [IDX_W-1:0]   evt_id_q;
    logic               evt_repeat_q;
    logic [IDX_W-1:0]   last_grant_q;

    // Press capture and overflow
    logic [N_BTN-1:0]   pending_q;
    logic [N_BTN-1:0]   pending_d;
    logic               overflow_q;
    logic               overflow_d;

    // Repeat engine
    logic               rep_armed_q;
    logic [IDX_W-1:0]   rep_id_q;
    logic [31:0]        rep_cnt_q;
    logic               rep_req_q;
    logic               rep_use_period_q;

    // Combinational helpers
    logic [SUM_W-1:0]   sum_s;
    logic [IDX_W-1:0]   cand_s;
    logic [IDX_W-1:0]   sel_s;
    logic               any_pend_s;
    logic               load_fresh_s;
    logic               load_rep_s;
    logic [N_BTN-1:0]   load_mask_s;
    logic               accept_s;
    logic               accept_fresh_s;
    logic               lost_s;
    logic [31:0]        rep_thr_s;
    logic               rep_held_s;
    logic               rep_hit_s;

    // Round-robin pick: first pending bit searching upward from last_grant+1.
    // Iterating from the farthest candidate down to the nearest lets the
    // nearest pending candidate win by being assigned last.
    always_comb begin
        sum_s      = '0;
        cand_s     = '0;
        sel_s      = '0;
        any_pend_s = |pending_q;
        for (int k = N_BTN; k >= 1; k--) begin
            sum_s = {1'b0, last_grant_q} + SUM_W'(k);
            if (sum_s >= SUM_W'(N_BTN)) begin
                cand_s = IDX_W'(sum_s - SUM_W'(N_BTN));
            end else begin
                cand_s = sum_s[IDX_W-1:0];
            end
            sel_s = pending_q[cand_s] ? cand_s : sel_s;
        end
    end

    // Decide what the FSM loads this cycle; fresh presses beat a repeat.
    always_comb begin
        load_fresh_s   = 1'b0;
        load_rep_s     = 1'b0;
        load_mask_s    = '0;
        accept_s       = (state_q == ST_OFFER) && evt_ready;
        accept_fresh_s = accept_s && !evt_repeat_q;
        if (state_q == ST_IDLE) begin
            if (any_pend_s) begin
                load_fresh_s = 1'b1;
                load_mask_s  = {{(N_BTN-1){1'b0}}, 1'b1} << sel_s;
            end else begin
                load_rep_s = rep_req_q;
            end
        end else begin
            load_fresh_s = 1'b0;
            load_rep_s   = 1'b0;
        end
    end

    // Pending update and lost-press detection. A press in the same cycle its
    // button is loaded re-arms the pending bit as a new event.
    always_comb begin
        pending_d  = (pending_q & ~load_mask_s) | btn_pressed;
        lost_s     = |(btn_pressed & pending_q & ~load_mask_s);
        overflow_d = overflow_q;
        if (lost_s) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Repeat threshold selection and hit detection. The hit is taken on the
    // cycle the incremented count would reach the threshold, so the count
    // register itself only ever holds values below the threshold.
    always_comb begin
        rep_thr_s  = rep_use_period_q ? PERIOD_C : DELAY_C;
        rep_held_s = btn_state[rep_id_q];
        rep_hit_s  = ((rep_cnt_q + 32'd1) == rep_thr_s);
    end

    // Pending bits and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Output FSM: IDLE loads the next event, OFFER holds it until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            evt_repeat_q <= 1'b0;
            last_grant_q <= IDX_W'(N_BTN - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_fresh_s) begin
                        state_q      <= ST_OFFER;
                        evt_valid_q  <= 1'b1;
                        evt_id_q     <= sel_s;
                        evt_repeat_q <= 1'b0;
                        last_grant_q <= sel_s;
                    end else if (load_rep_s) begin
                        state_q      <= ST_OFFER;
                        evt_valid_q  <= 1'b1;
                        evt_id_q     <= rep_id_q;
                        evt_repeat_q <= 1'b1;
                    end else begin
                        evt_valid_q  <= 1'b0;
                    end
                end
                ST_OFFER: begin
                    if (evt_ready) begin
                        state_q     <= ST_IDLE;
                        evt_valid_q <= 1'b0;
                    end else begin
                        evt_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    evt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Repeat engine: armed by accepting a fresh event, counts while the
    // button stays held, raises one request per threshold, disarms on release.
    // A request that is still outstanding when the next threshold hits is
    // simply kept (the extra repeat is dropped).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_armed_q      <= 1'b0;
            rep_id_q         <= '0;
            rep_cnt_q        <= '0;
            rep_req_q        <= 1'b0;
            rep_use_period_q <= 1'b0;
        end else if (accept_fresh_s) begin
            rep_armed_q      <= REP_EN_C;
            rep_id_q         <= evt_id_q;
            rep_cnt_q        <= '0;
            rep_req_q        <= 1'b0;
            rep_use_period_q <= 1'b0;
        end else if (rep_armed_q) begin
            if (!rep_held_s) begin
                rep_armed_q      <= 1'b0;
                rep_cnt_q        <= '0;
                rep_req_q        <= 1'b0;
                rep_use_period_q <= 1'b0;
            end else if (rep_hit_s) begin
                rep_cnt_q        <= '0;
                rep_use_period_q <= 1'b1;
                rep_req_q        <= !load_rep_s;
            end else begin
                rep_cnt_q        <= rep_cnt_q + 32'd1;
                rep_req_q        <= rep_req_q && !load_rep_s;
            end
        end else begin
            rep_req_q <= rep_req_q && !load_rep_s;
        end
    end

    assign evt_valid  = evt_valid_q;
    assign evt_id     = evt_id_q;
    assign evt_repeat = evt_repeat_q;
    assign overflow   = overflow_q;

endmodule
